estu_layer_sched: RTL and testbench
===================================

ESTU_LAYER_SCHED -- requirements
Module: estu_layer_sched

Interface
REQ-001 Parameter MAX_LAYERS, default 16, maximum layers per timestep.
REQ-002 Parameter PC_STRIDE, default 6, program-counter words per layer op.
REQ-003 Parameter TS_W, default 8, timestep counter width.
REQ-004 i_clk  in  1  sole clock; i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_start  in  1  run request pulse; i_abort  in  1  synchronous run cancel.
REQ-006 i_num_ts  in  TS_W  timesteps per run; i_num_layers  in  4  layers per timestep.
REQ-007 i_layer_done  in  1  engine finished current layer (pulse).
REQ-008 o_layer_start  out  1  one-cycle engine kick; o_pc  out  8  layer start PC.
REQ-009 o_timestep  out  TS_W  current timestep; o_buf_sel  out  1  ping-pong select (0: read sm1/intmem1, write sm2/intmem2).
REQ-010 o_last_layer  out  1  current layer is final layer; o_valid_last  out  1  one-cycle last-layer result strobe.
REQ-011 o_busy  out  1  run in progress; o_done  out  1  one-cycle run completion pulse; o_err  out  1  watchdog flag (sticky until next i_start).

Function
REQ-012 States: IDLE, ISSUE, RUN, SWAP, NEXT_TS, DONE; all outputs registered.
REQ-013 IDLE: i_start=1 latches i_num_ts/i_num_layers, clears layer/ts counters, buf_sel=0, goes ISSUE; i_start elsewhere ignored.
REQ-014 i_num_ts=0 or i_num_layers=0 at start: IDLE->DONE directly, no o_layer_start issued.
REQ-015 ISSUE: o_layer_start=1 exactly one cycle, o_pc=layer*PC_STRIDE (8-bit, truncated), -> RUN unconditionally.
REQ-016 RUN: waits i_layer_done; i_layer_done outside RUN ignored; latency start-accepted to first o_layer_start = 1 cycle.
REQ-017 RUN with done and layer<num_layers-1: -> SWAP; SWAP increments layer, toggles o_buf_sel, -> ISSUE.
REQ-018 RUN with done and layer=num_layers-1: -> NEXT_TS; NEXT_TS pulses o_valid_last one cycle.
REQ-019 NEXT_TS: ts=num_ts-1 -> DONE, else ts+1, layer=0, o_buf_sel=0, -> ISSUE.
REQ-020 DONE: o_done=1 one cycle, o_busy drops same cycle, -> IDLE.
REQ-021 o_busy=1 in every state except IDLE and DONE.
REQ-022 o_last_layer = (layer==num_layers-1) whenever busy, else 0.
REQ-023 i_abort=1 in any busy state: -> IDLE next cycle, no o_done, no o_valid_last, counters held for readback; abort has priority over i_layer_done.
REQ-024 i_num_layers > MAX_LAYERS clamps to MAX_LAYERS at latch.
REQ-025 o_timestep holds last value after DONE until next accepted i_start.

Reset
REQ-026 i_rst asserted: state=IDLE, all counters 0, every output 0, immediately regardless of state (mid-run included).
REQ-027 First i_start sampled on first i_clk edge after i_rst deasserts is accepted.

Configuration
REQ-028 Macro ESTU_SCHED_WATCHDOG_EN compiled in: 16-bit cycle counter runs in RUN, cleared on ISSUE; reaching 0xFFFF sets o_err=1, -> IDLE, no o_done.
REQ-029 Without ESTU_SCHED_WATCHDOG_EN: no counter, o_err tied 0, RUN waits indefinitely.

Structure
REQ-030 Shared package estu_pkg holds state enumeration, PC_STRIDE default, TS_W default, watchdog limit constant.
REQ-031 No sub-module; single FSM plus counters; optional watchdog inline under the macro.

Verification
REQ-032 num_ts=2, num_layers=3, engine done 5 cycles after each kick -> 6 kicks, o_pc 0,6,12 per ts, o_buf_sel 0,1,0, o_valid_last twice, o_done once.
REQ-033 num_ts=0, start -> o_done one cycle later, zero kicks, o_busy never 1.
REQ-034 i_abort during second layer of ts 1 -> IDLE next cycle, no o_done, o_timestep=1 retained.
REQ-035 i_start and i_layer_done pulsed while IDLE, and i_start while RUN -> no state change, no extra kick.
REQ-036 i_rst pulse mid-RUN -> all outputs 0 asynchronously; subsequent start runs cleanly from ts 0.
REQ-037 Macro defined, engine never answers -> o_err=1 after 65535 RUN cycles, o_busy=0, no o_done.

Source files
------------

// File: rtl/estu_pkg.sv
// Shared types and constants for the ESTU layer scheduler.
package estu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_SWAP,
        S_NEXT_TS,
        S_DONE
    } sched_state_e;

    localparam int          MAX_LAYERS_DEF = 16;
    localparam int          PC_STRIDE_DEF  = 6;
    localparam int          TS_W_DEF       = 8;
    localparam logic [15:0] WD_LIMIT       = 16'hFFFF;

    // Start PC of a layer op; wraps into the 8-bit PC space.
    function automatic logic [7:0] layer_pc(input logic [3:0] layer, input int stride);
        logic [31:0] p;
        p = 32'(layer) * 32'(stride);
        return p[7:0];
    endfunction

endpackage

// File: rtl/estu_layer_sched.sv
// Layer/timestep scheduler: kicks the engine once per layer, ping-pongs buffers.
// Optional run watchdog compiled in with `define ESTU_SCHED_WATCHDOG_EN.
module estu_layer_sched
    import estu_pkg::*;
#(
    parameter int MAX_LAYERS = MAX_LAYERS_DEF,
    parameter int PC_STRIDE  = PC_STRIDE_DEF,
    parameter int TS_W       = TS_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [TS_W-1:0] i_num_ts,
    input  logic [3:0]      i_num_layers,
    input  logic            i_layer_done,
    output logic            o_layer_start,
    output logic [7:0]      o_pc,
    output logic [TS_W-1:0] o_timestep,
    output logic            o_buf_sel,
    output logic            o_last_layer,
    output logic            o_valid_last,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    sched_state_e    state_q, state_d;
    logic [TS_W-1:0] num_ts_q, num_ts_d, ts_q, ts_d;
    logic [3:0]      num_layers_q, num_layers_d, layer_q, layer_d, nl_in;
    logic            buf_q, buf_d, busy_d;
    logic            start_q, vlast_q, busy_q, done_q, last_q;
    logic [7:0]      pc_q;
`ifdef ESTU_SCHED_WATCHDOG_EN
    logic [15:0]     wd_q, wd_d;
    logic            err_q, err_d;
`endif

    assign nl_in = (int'(i_num_layers) > MAX_LAYERS) ? 4'(MAX_LAYERS) : i_num_layers;

    always_comb begin
        state_d      = state_q;
        num_ts_d     = num_ts_q;
        num_layers_d = num_layers_q;
        ts_d         = ts_q;
        layer_d      = layer_q;
        buf_d        = buf_q;
`ifdef ESTU_SCHED_WATCHDOG_EN
        wd_d         = wd_q;
        err_d        = err_q;
`endif
        // Abort wins over everything in busy states; counters stay for readback.
        if (i_abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (i_start) begin
                    num_ts_d     = i_num_ts;
                    num_layers_d = nl_in;
                    ts_d         = '0;
                    layer_d      = '0;
                    buf_d        = 1'b0;
`ifdef ESTU_SCHED_WATCHDOG_EN
                    err_d        = 1'b0;
`endif
                    state_d      = (i_num_ts == '0 || nl_in == '0) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
`ifdef ESTU_SCHED_WATCHDOG_EN
                    wd_d    = '0;
`endif
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (i_layer_done) begin
                        state_d = (layer_q == num_layers_q - 4'd1) ? S_NEXT_TS : S_SWAP;
`ifdef ESTU_SCHED_WATCHDOG_EN
                    end else if (wd_q + 16'd1 == WD_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + 16'd1;
`endif
                    end
                end
                S_SWAP: begin
                    layer_d = layer_q + 4'd1;
                    buf_d   = ~buf_q;
                    state_d = S_ISSUE;
                end
                S_NEXT_TS: begin
                    if (ts_q == num_ts_q - TS_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        ts_d    = ts_q + TS_W'(1);
                        layer_d = '0;
                        buf_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            num_ts_q     <= '0;
            num_layers_q <= '0;
            ts_q         <= '0;
            layer_q      <= '0;
            buf_q        <= 1'b0;
            start_q      <= 1'b0;
            pc_q         <= '0;
            vlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            last_q       <= 1'b0;
`ifdef ESTU_SCHED_WATCHDOG_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            num_ts_q     <= num_ts_d;
            num_layers_q <= num_layers_d;
            ts_q         <= ts_d;
            layer_q      <= layer_d;
            buf_q        <= buf_d;
            start_q      <= (state_d == S_ISSUE);
            pc_q         <= layer_pc(layer_d, PC_STRIDE);
            vlast_q      <= (state_d == S_NEXT_TS);
            busy_q       <= busy_d;
            done_q       <= (state_d == S_DONE);
            last_q       <= busy_d && (layer_d == num_layers_d - 4'd1);
`ifdef ESTU_SCHED_WATCHDOG_EN
            wd_q         <= wd_d;
            err_q        <= err_d;
`endif
        end
    end

    assign o_layer_start = start_q;
    assign o_pc          = pc_q;
    assign o_timestep    = ts_q;
    assign o_buf_sel     = buf_q;
    assign o_last_layer  = last_q;
    assign o_valid_last  = vlast_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
`ifdef ESTU_SCHED_WATCHDOG_EN
    assign o_err         = err_q;
`else
    assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_estu_layer_sched.sv
// Scheduler bench: event-level reference model, directed scenarios, random traffic.
module tb_estu_layer_sched;

    localparam int TS_W   = 8;
    localparam int MAXL   = 16;
    localparam int STRIDE = 6;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_start = 1'b0, i_abort = 1'b0;
    logic [TS_W-1:0] i_num_ts = '0;
    logic [3:0]      i_num_layers = '0;
    logic            i_layer_done;
    logic            eng_done = 1'b0, xtra_done = 1'b0;
    logic            o_layer_start, o_buf_sel, o_last_layer, o_valid_last, o_busy, o_done, o_err;
    logic [7:0]      o_pc;
    logic [TS_W-1:0] o_timestep;

    assign i_layer_done = eng_done | xtra_done;

    estu_layer_sched #(.MAX_LAYERS(MAXL), .PC_STRIDE(STRIDE), .TS_W(TS_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_num_ts(i_num_ts), .i_num_layers(i_num_layers), .i_layer_done(i_layer_done),
        .o_layer_start(o_layer_start), .o_pc(o_pc), .o_timestep(o_timestep),
        .o_buf_sel(o_buf_sel), .o_last_layer(o_last_layer), .o_valid_last(o_valid_last),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0, fails = 0;
    int kick_cnt = 0, vlast_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int cap_pc[$], cap_buf[$];
    int epc[6]  = '{0, 6, 12, 0, 6, 12};
    int ebuf[6] = '{0, 1, 0, 0, 1, 0};
    logic chk_en = 1'b1, eng_en = 1'b1;
    int   eng_dly = 5, eng_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got no event within budget, expected one", name);
    endtask

    function automatic int clampl(input int n);
        return (n > MAXL) ? MAXL : n;
    endfunction

    // Reference model: what must be visible in each cycle, built from run progress
    // (timestep, layer) and the scheduling delays between engine events.
    int   m_nts, m_nl, m_ts, m_layer, pk_ts, pk_layer;
    logic m_buf, pk_buf, m_active, m_wait, m_pk, m_pd, m_kicked;
    logic x_kick, x_vlast, x_done;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_nts <= 0; m_nl <= 0; m_ts <= 0; m_layer <= 0; pk_ts <= 0; pk_layer <= 0;
            m_buf <= 0; pk_buf <= 0; m_active <= 0; m_wait <= 0; m_pk <= 0; m_pd <= 0;
            m_kicked <= 0; x_kick <= 0; x_vlast <= 0; x_done <= 0;
        end else begin
            x_kick <= 0; x_vlast <= 0; x_done <= 0;
            if (m_active && i_abort) begin
                m_active <= 0; m_wait <= 0; m_pk <= 0; m_pd <= 0; m_kicked <= 0;
            end else if (m_active) begin
                if (m_pd) begin
                    x_done <= 1; m_active <= 0; m_pd <= 0;
                end else if (m_pk) begin
                    x_kick <= 1; m_pk <= 0; m_kicked <= 1;
                    m_ts <= pk_ts; m_layer <= pk_layer; m_buf <= pk_buf;
                end else if (m_kicked) begin
                    m_kicked <= 0; m_wait <= 1;
                end else if (m_wait && i_layer_done) begin
                    m_wait <= 0;
                    if (m_layer < m_nl - 1) begin
                        m_pk <= 1; pk_ts <= m_ts; pk_layer <= m_layer + 1; pk_buf <= ~m_buf;
                    end else begin
                        x_vlast <= 1;
                        if (m_ts == m_nts - 1) m_pd <= 1;
                        else begin m_pk <= 1; pk_ts <= m_ts + 1; pk_layer <= 0; pk_buf <= 0; end
                    end
                end
            end else if (!x_done && i_start) begin
                m_nts <= int'(i_num_ts); m_nl <= clampl(int'(i_num_layers));
                m_ts <= 0; m_layer <= 0; m_buf <= 0;
                if (i_num_ts == '0 || clampl(int'(i_num_layers)) == 0) x_done <= 1;
                else begin m_active <= 1; x_kick <= 1; m_kicked <= 1; end
            end
        end
    end

    // Compare process and event counters.
    initial forever begin
        @(negedge i_clk);
        if (o_layer_start) begin
            kick_cnt++;
            cap_pc.push_back(int'(o_pc));
            cap_buf.push_back(int'(o_buf_sel));
        end
        if (o_valid_last) vlast_cnt++;
        if (o_done) done_cnt++;
        if (o_busy) busy_cnt++;
        if (!i_rst && chk_en) begin
            chk("busy", o_busy, m_active);
            chk("kick", o_layer_start, x_kick);
            chk("valid_last", o_valid_last, x_vlast);
            chk("done", o_done, x_done);
            chk("timestep", o_timestep, m_ts);
            chk("buf_sel", o_buf_sel, m_buf);
            chk("pc", o_pc, (m_layer * STRIDE) & 255);
            chk("last_layer", o_last_layer, m_active && (m_layer == m_nl - 1));
            chk("err", o_err, 0);
        end
    end

    // Engine responder: answers each kick after eng_dly cycles (0 = random 1..6).
    initial forever begin
        @(negedge i_clk);
        eng_done = 1'b0;
        if (i_rst || !eng_en) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) eng_done = 1'b1;
            end
            if (o_layer_start) eng_cnt = (eng_dly != 0) ? eng_dly : int'($urandom_range(1, 6));
        end
    end

    task automatic start_run(input int nts, input int nl);
        i_num_ts = TS_W'(nts);
        i_num_layers = 4'(nl);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 500) begin @(negedge i_clk); n++; end
        if (done_cnt == base) timeout(name);
        @(negedge i_clk);
    endtask

    int kb, vb, db, bb, r;

    initial begin
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_kick", o_layer_start, 0);
        chk("rst_ts", o_timestep, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_done", o_done, 0);
        i_rst = 1'b0;

        // Two timesteps of three layers, engine answers after 5 cycles.
        kb = kick_cnt; vb = vlast_cnt; db = done_cnt;
        start_run(2, 3);
        chk("first_kick_latency", o_layer_start, 1);
        wait_done(db, "run_2x3");
        chk("run_2x3_kicks", kick_cnt - kb, 6);
        for (int i = 0; i < 6; i++) begin
            chk("run_2x3_pc", cap_pc[kb + i], epc[i]);
            chk("run_2x3_buf", cap_buf[kb + i], ebuf[i]);
        end
        chk("run_2x3_vlast", vlast_cnt - vb, 2);
        chk("run_2x3_done", done_cnt - db, 1);
        chk("ts_held_after_done", o_timestep, 1);

        // Empty runs finish immediately without a kick.
        kb = kick_cnt; db = done_cnt; bb = busy_cnt;
        start_run(0, 3);
        chk("zero_ts_done", o_done, 1);
        repeat (3) @(negedge i_clk);
        start_run(2, 0);
        chk("zero_layers_done", o_done, 1);
        repeat (3) @(negedge i_clk);
        chk("empty_kicks", kick_cnt - kb, 0);
        chk("empty_busy", busy_cnt - bb, 0);
        chk("empty_dones", done_cnt - db, 2);

        // Abort during the second layer of timestep 1.
        db = done_cnt;
        start_run(3, 3);
        r = 0;
        while (!(o_layer_start && o_timestep == 1 && o_pc == 8'd6) && r < 300) begin
            @(negedge i_clk); r++;
        end
        if (r >= 300) timeout("abort_target");
        repeat (2) @(negedge i_clk);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_ts", o_timestep, 1);
        repeat (20) @(negedge i_clk);
        chk("abort_no_done", done_cnt - db, 0);

        // Stray done while idle, stray start while running.
        kb = kick_cnt; db = done_cnt;
        xtra_done = 1'b1;
        @(negedge i_clk);
        xtra_done = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("idle_done_kicks", kick_cnt - kb, 0);
        start_run(1, 2);
        repeat (3) @(negedge i_clk);
        start_run(3, 5);
        wait_done(db, "stray_start");
        chk("stray_start_kicks", kick_cnt - kb, 2);

        // Asynchronous reset in the middle of timestep 1.
        start_run(2, 2);
        r = 0;
        while (!(o_layer_start && o_timestep == 1) && r < 300) begin @(negedge i_clk); r++; end
        if (r >= 300) timeout("reset_target");
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_ts", o_timestep, 0);
        chk("arst_last", o_last_layer, 0);
        chk("arst_pc", o_pc, 0);
        chk("arst_err", o_err, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        kb = kick_cnt; db = done_cnt;
        start_run(1, 2);
        chk("post_rst_ts", o_timestep, 0);
        wait_done(db, "post_rst_run");
        chk("post_rst_kicks", kick_cnt - kb, 2);

        // Random traffic with random engine latency.
        eng_dly = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge i_clk);
            i_start = 1'b0; i_abort = 1'b0; xtra_done = 1'b0;
            r = int'($urandom_range(0, 99));
            if (!o_busy && r < 20) begin
                i_start = 1'b1;
                i_num_ts = TS_W'($urandom_range(0, 3));
                i_num_layers = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
            end else if (o_busy && r < 2) begin
                i_abort = 1'b1;
            end else if (r < 4) begin
                xtra_done = 1'b1;
            end else if (r < 6) begin
                i_start = 1'b1;
                i_num_ts = TS_W'($urandom_range(0, 3));
            end
        end
        i_start = 1'b0; i_abort = 1'b0; xtra_done = 1'b0;
        repeat (5) @(negedge i_clk);

`ifdef ESTU_SCHED_WATCHDOG_EN
        // Engine never answers: watchdog trips after 65535 RUN cycles.
        while (o_busy) @(negedge i_clk);
        repeat (2) @(negedge i_clk);
        eng_en = 1'b0; chk_en = 1'b0; db = done_cnt;
        start_run(1, 1);
        r = 0;
        while (!o_err && r < 70000) begin @(negedge i_clk); r++; end
        if (!o_err) timeout("watchdog");
        chk("wd_cycles", r, 65536);
        chk("wd_busy", o_busy, 0);
        repeat (3) @(negedge i_clk);
        chk("wd_no_done", done_cnt - db, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0; eng_en = 1'b1; chk_en = 1'b1;
        @(negedge i_clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
